// File: rtl/camera_controller_pkg.sv
// Shared camera definitions: move key codes, controller states,
// default timing parameters and the key priority encoder.
package camera_controller_pkg;

    localparam logic [2:0] KEY_UPOS = 3'b000;
    localparam logic [2:0] KEY_UNEG = 3'b001;
    localparam logic [2:0] KEY_VPOS = 3'b010;
    localparam logic [2:0] KEY_VNEG = 3'b011;
    localparam logic [2:0] KEY_WPOS = 3'b100;
    localparam logic [2:0] KEY_WNEG = 3'b101;
    localparam logic [2:0] KEY_NONE = 3'b111;

    localparam int NUM_KEYS         = 6;
    localparam int DEF_DEBOUNCE_CYC = 16;
    localparam int DEF_TICK_CYC     = 4;
    localparam int DEF_CNT_MAX      = 255;
    localparam int DEF_HOLD_CYC     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_RELEASED,
        ST_ISSUE,
        ST_HOLD
    } cam_state_e;

    // Lowest set bit wins; bit i maps to code i.
    function automatic logic [2:0] key_encode(
        input logic [NUM_KEYS-1:0] db
    );
        logic [2:0] code;
        code = KEY_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (db[i]) begin
                code = 3'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/camera_controller_if.sv
// Camera controller bus: raw keys and frame pulse in,
// move request (ld_curr_camera, key, cnt) and busy out.
interface camera_controller_if;
    import camera_controller_pkg::*;

    logic [NUM_KEYS-1:0] key_raw;
    logic                frame_done;
    logic                ld_curr_camera;
    logic [2:0]          key;
    logic [31:0]         cnt;
    logic                busy;

    // master: the controller producing the move request
    modport master (
        input  key_raw,
        input  frame_done,
        output ld_curr_camera,
        output key,
        output cnt,
        output busy
    );

    // slave: button source / datapath consuming the request
    modport slave (
        output key_raw,
        output frame_done,
        input  ld_curr_camera,
        input  key,
        input  cnt,
        input  busy
    );

endinterface

// File: rtl/camera_controller_key_debounce.sv
// One key bit: 2-FF synchronizer plus a stability counter.
// Ports: clk, rst (async active-low), raw_i (async), db_o.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic db_o
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    // Expose the accepted value on the cycle it is accepted so the
    // controller reacts on the same edge db_q updates.
    assign db_o = db_d;

endmodule

// File: rtl/camera_controller.sv
// Camera move front end: debounces six keys, accumulates a hold
// count and issues one ld_curr_camera per frame, then holds.
// Ports: clk, rst (async active-low), bus (camera_controller_if.master).
module camera_controller
    import camera_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int TICK_CYC     = DEF_TICK_CYC,
    parameter int CNT_MAX      = DEF_CNT_MAX,
    parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    camera_controller_if.master        bus
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic [NUM_KEYS-1:0] db;
    logic                active;
    logic [2:0]          code;

    cam_state_e          state_q;
    cam_state_e          state_d;
    logic [2:0]          key_q;
    logic [2:0]          key_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [TW-1:0]       tick_q;
    logic [TW-1:0]       tick_d;
    logic [HW-1:0]       hold_q;
    logic [HW-1:0]       hold_d;
    logic                ld_q;
    logic                ld_d;
    logic                busy_q;
    logic                busy_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw_i(bus.key_raw[i]),
            .db_o (db[i])
        );
    end

    assign active = |db;
    assign code   = key_encode(db);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        tick_d  = tick_q;
        hold_d  = hold_q;

        unique case (state_q)
            ST_IDLE: begin
                key_d  = KEY_NONE;
                cnt_d  = '0;
                tick_d = '0;
                if (active) begin
                    state_d = ST_ACCUM;
                    key_d   = code;
                end
            end
            ST_ACCUM: begin
                if (!active) begin
                    if (cnt_q != '0) begin
                        state_d = ST_RELEASED;
                    end else begin
                        state_d = ST_IDLE;
                        key_d   = KEY_NONE;
                    end
                end else if (code != key_q) begin
                    // New direction restarts the count and
                    // swallows a same-cycle frame_done.
                    key_d  = code;
                    cnt_d  = '0;
                    tick_d = '0;
                end else if (bus.frame_done && cnt_q != '0) begin
                    state_d = ST_ISSUE;
                end else if (tick_q == TW'(TICK_CYC - 1)) begin
                    tick_d = '0;
                    if (cnt_q != CW'(CNT_MAX)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            ST_RELEASED: begin
                // A pending frame wins over a re-press.
                if (bus.frame_done) begin
                    state_d = ST_ISSUE;
                end else if (active) begin
                    state_d = ST_ACCUM;
                    if (code != key_q) begin
                        key_d  = code;
                        cnt_d  = '0;
                        tick_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_HOLD;
                hold_d  = '0;
            end
            ST_HOLD: begin
                if (hold_q == HW'(HOLD_CYC - 1)) begin
                    hold_d = '0;
                    cnt_d  = '0;
                    tick_d = '0;
                    if (active) begin
                        state_d = ST_ACCUM;
                        key_d   = code;
                    end else begin
                        state_d = ST_IDLE;
                        key_d   = KEY_NONE;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                key_d   = KEY_NONE;
                cnt_d   = '0;
                tick_d  = '0;
                hold_d  = '0;
            end
        endcase

        ld_d   = (state_d == ST_ISSUE);
        busy_d = (state_d == ST_ISSUE) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            key_q   <= KEY_NONE;
            cnt_q   <= '0;
            tick_q  <= '0;
            hold_q  <= '0;
            ld_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            hold_q  <= hold_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ld_curr_camera = ld_q;
    assign bus.key            = key_q;
    assign bus.cnt            = 32'(cnt_q);
    assign bus.busy           = busy_q;

endmodule
